// File: rtl/ov5640_cfg_pkg.sv
// Shared state encoding, ROM entry layout and timing constants for the OV5640 configurator.
// Optional NACK retry support is enabled with the OV5640_CFG_RETRY_EN macro (see ov5640_cfg_ctrl).
package ov5640_cfg_pkg;

  typedef enum logic [3:0] {
    ST_PWR,
    ST_RST,
    ST_INIT,
    ST_FETCH,
    ST_REQ,
    ST_WAIT,
    ST_DLY,
    ST_ADV,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  // A table entry whose address is DLY_MARKER is a delay of <data> milliseconds.
  localparam logic [15:0] DLY_MARKER = 16'hFFFF;

  localparam int ROM_W    = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int CNT_W    = 20;

  function automatic logic [ROM_W-1:0] rom_entry(input logic [15:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// Combinational OV5640 register table: soft reset, 5 ms settle, then RGB565 setup.
// Unlisted indices read as zero-length delays so they never generate SCCB traffic.
module ov5640_cfg_rom
  import ov5640_cfg_pkg::*;
(
  input  logic [7:0]  index,
  output logic [15:0] addr,
  output logic [7:0]  data
);

  logic [ROM_W-1:0] entry;

  always_comb begin
    case (index)
      8'd0:    entry = rom_entry(16'h3008, 8'h82);
      8'd1:    entry = rom_entry(DLY_MARKER, 8'h05);
      8'd2:    entry = rom_entry(16'h3103, 8'h03);
      8'd3:    entry = rom_entry(16'h3017, 8'hFF);
      8'd4:    entry = rom_entry(16'h3018, 8'hFF);
      8'd5:    entry = rom_entry(16'h3034, 8'h1A);
      8'd6:    entry = rom_entry(16'h3035, 8'h11);
      8'd7:    entry = rom_entry(16'h3036, 8'h46);
      8'd8:    entry = rom_entry(16'h3037, 8'h13);
      8'd9:    entry = rom_entry(16'h3108, 8'h01);
      8'd10:   entry = rom_entry(16'h3630, 8'h36);
      8'd11:   entry = rom_entry(16'h3631, 8'h0E);
      8'd12:   entry = rom_entry(16'h3632, 8'hE2);
      8'd13:   entry = rom_entry(16'h3633, 8'h12);
      8'd14:   entry = rom_entry(16'h3621, 8'hE0);
      8'd15:   entry = rom_entry(16'h3704, 8'hA0);
      8'd16:   entry = rom_entry(16'h3703, 8'h5A);
      8'd17:   entry = rom_entry(16'h3715, 8'h78);
      8'd18:   entry = rom_entry(16'h3717, 8'h01);
      8'd19:   entry = rom_entry(16'h370B, 8'h60);
      8'd20:   entry = rom_entry(16'h3705, 8'h1A);
      8'd21:   entry = rom_entry(16'h3905, 8'h02);
      8'd22:   entry = rom_entry(16'h3906, 8'h10);
      8'd23:   entry = rom_entry(16'h3901, 8'h0A);
      8'd24:   entry = rom_entry(16'h4300, 8'h61);
      8'd25:   entry = rom_entry(16'h501F, 8'h01);
      8'd26:   entry = rom_entry(16'h3820, 8'h40);
      8'd27:   entry = rom_entry(16'h3821, 8'h06);
      8'd28:   entry = rom_entry(16'h3808, 8'h02);
      8'd29:   entry = rom_entry(16'h3809, 8'h80);
      8'd30:   entry = rom_entry(16'h380A, 8'h01);
      8'd31:   entry = rom_entry(16'h380B, 8'hE0);
      8'd32:   entry = rom_entry(16'h3008, 8'h02);
      default: entry = rom_entry(DLY_MARKER, 8'h00);
    endcase
  end

  assign addr = entry[ADDR_MSB:ADDR_LSB];
  assign data = entry[DATA_MSB:DATA_LSB];

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 power-up sequencer and register-table writer driving an SCCB master via req/ack/done.
// Define OV5640_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before failing.
module ov5640_cfg_ctrl
  import ov5640_cfg_pkg::*;
#(
  parameter int T_PWDN_CYC = 300_000,
  parameter int T_RST_CYC  = 100_000,
  parameter int T_INIT_CYC = 1_000_000,
  parameter int CYC_PER_MS = 50_000,
  parameter int WR_GAP_CYC = 16,
  parameter int REG_NUM    = 250
`ifdef OV5640_CFG_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_restart,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic        sccb_req,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_ack,
  input  logic        sccb_done,
  input  logic        sccb_err,
  output logic [7:0]  cfg_idx,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(T_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT_CYC - 1);
  localparam logic [CNT_W-1:0] MS_LAST   = CNT_W'(CYC_PER_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(WR_GAP_CYC - 1);
  localparam logic [7:0]       IDX_LAST  = 8'(REG_NUM - 1);

  cfg_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       ms_cnt;
  logic [15:0]      rom_addr;
  logic [7:0]       rom_data;
  logic             xfer_done;
  logic             nack_retry;

  ov5640_cfg_rom u_rom (
    .index (cfg_idx),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // A done coinciding with the accepting ack completes the transfer directly from REQ.
  assign xfer_done = sccb_done && ((state == ST_WAIT) || (state == ST_REQ && sccb_ack));

`ifdef OV5640_CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt;

  assign nack_retry = (retry_cnt != RETRY_W'(MAX_RETRY));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      retry_cnt <= '0;
    end else if (state == ST_ADV || state == ST_PWR) begin
      retry_cnt <= '0;
    end else if (xfer_done && sccb_err && nack_retry) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end
`else
  assign nack_retry = 1'b0;
`endif

  // cnt counts elapsed cycles within the current timed state and is zeroed on every entry.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_PWR;
      cnt        <= '0;
      ms_cnt     <= '0;
      cam_pwdn   <= 1'b1;
      cam_rst_n  <= 1'b0;
      sccb_req   <= 1'b0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      cfg_idx    <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      case (state)
        ST_PWR: begin
          if (cnt == PWDN_LAST) begin
            cnt      <= '0;
            cam_pwdn <= 1'b0;
            state    <= ST_RST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RST: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            cam_rst_n <= 1'b1;
            state     <= ST_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            state <= ST_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          if (rom_addr == DLY_MARKER) begin
            ms_cnt <= rom_data;
            cnt    <= '0;
            state  <= ST_DLY;
          end else begin
            sccb_addr  <= rom_addr;
            sccb_wdata <= rom_data;
            sccb_req   <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sccb_ack) begin
            sccb_req <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
        end
        // Exit on the last cycle of the last millisecond so the delay spans exactly data*CYC_PER_MS.
        ST_DLY: begin
          if (ms_cnt == 8'd0 || (ms_cnt == 8'd1 && cnt == MS_LAST)) begin
            state <= ST_ADV;
          end else if (cnt == MS_LAST) begin
            cnt    <= '0;
            ms_cnt <= ms_cnt - 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ADV: begin
          if (cfg_idx == IDX_LAST) begin
            cfg_done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cfg_idx <= cfg_idx + 8'd1;
            cnt     <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          sccb_req <= 1'b0;
          if (cfg_restart) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_idx   <= '0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            cnt       <= '0;
            state     <= ST_PWR;
          end
        end
        default: state <= ST_PWR;
      endcase

      if (xfer_done) begin
        if (!sccb_err) begin
          state <= ST_ADV;
        end else if (nack_retry) begin
          cnt   <= '0;
          state <= ST_GAP;
        end else begin
          cfg_err <= 1'b1;
          state   <= ST_ERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Directed bench for ov5640_cfg_ctrl with a behavioural SCCB master (ack next cycle, done 8 later).
// Build with OV5640_CFG_RETRY_EN defined to check the NACK retry variant.
`timescale 1ns/1ps
module tb_ov5640_cfg_ctrl;

  logic        sys_clk     = 1'b0;
  logic        sys_rst     = 1'b1;
  logic        cfg_restart = 1'b0;
  logic        cam_pwdn;
  logic        cam_rst_n;
  logic        sccb_req;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_ack;
  logic        sccb_done;
  logic        sccb_err;
  logic [7:0]  cfg_idx;
  logic        cfg_done;
  logic        cfg_err;

  always #5 sys_clk = ~sys_clk;

  ov5640_cfg_ctrl #(
    .T_PWDN_CYC (10),
    .T_RST_CYC  (5),
    .T_INIT_CYC (20),
    .CYC_PER_MS (4),
    .WR_GAP_CYC (2),
    .REG_NUM    (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cfg_restart (cfg_restart),
    .cam_pwdn    (cam_pwdn),
    .cam_rst_n   (cam_rst_n),
    .sccb_req    (sccb_req),
    .sccb_addr   (sccb_addr),
    .sccb_wdata  (sccb_wdata),
    .sccb_ack    (sccb_ack),
    .sccb_done   (sccb_done),
    .sccb_err    (sccb_err),
    .cfg_idx     (cfg_idx),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          rise_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  data_q[$];
  int          pwdn_fall = -1;
  int          rstn_rise = -1;
  logic        req_d     = 1'b0;
  logic        pwdn_d    = 1'b1;
  logic        rstn_d    = 1'b0;

  int          stall_once = 0;
  int          nack_left  = 0;
  logic [15:0] nack_addr  = 16'h0000;

  // Edge number since reset release; at the negedge after edge n it reads n.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge sys_clk) begin
    if (sccb_req && !req_d) begin
      rise_q.push_back(cyc);
      addr_q.push_back(sccb_addr);
      data_q.push_back(sccb_wdata);
    end
    if (!cam_pwdn && pwdn_d)  pwdn_fall = cyc;
    if (cam_rst_n && !rstn_d) rstn_rise = cyc;
    req_d  = sccb_req;
    pwdn_d = cam_pwdn;
    rstn_d = cam_rst_n;
  end

  initial begin : master
    logic [15:0] cur_addr;
    sccb_ack  = 1'b0;
    sccb_done = 1'b0;
    sccb_err  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sccb_req && !sys_rst) begin
        cur_addr = sccb_addr;
        if (stall_once > 0) begin
          repeat (stall_once) @(negedge sys_clk);
          stall_once = 0;
        end
        sccb_ack = 1'b1;
        @(negedge sys_clk);
        sccb_ack = 1'b0;
        repeat (7) @(negedge sys_clk);
        sccb_done = 1'b1;
        sccb_err  = (cur_addr == nack_addr) && (nack_left > 0);
        if (sccb_err) nack_left--;
        @(negedge sys_clk);
        sccb_done = 1'b0;
        sccb_err  = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    rise_q.delete();
    addr_q.delete();
    data_q.delete();
    pwdn_fall = -1;
    rstn_rise = -1;
  endtask

  task automatic applyStimulus(input int stall, input logic [15:0] naddr, input int nacks);
    sys_rst     = 1'b1;
    cfg_restart = 1'b0;
    stall_once  = stall;
    nack_addr   = naddr;
    nack_left   = nacks;
    clearLog();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int end_cyc);
    end_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (cfg_done || cfg_err) begin
        end_cyc = cyc;
        break;
      end
    end
    if (end_cyc < 0) checkOutput("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  function automatic int riseAt(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  function automatic logic [15:0] addrAt(input int i);
    return (i < addr_q.size()) ? addr_q[i] : 16'h0000;
  endfunction

  function automatic logic [7:0] dataAt(input int i);
    return (i < data_q.size()) ? data_q[i] : 8'h00;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({cam_pwdn, cam_rst_n, sccb_req, cfg_done, cfg_err}), 32'b10000);
    checkOutput({tag, "_addr"}, 32'(sccb_addr), 32'h0);
    checkOutput({tag, "_wdata"}, 32'(sccb_wdata), 32'h0);
    checkOutput({tag, "_idx"}, 32'(cfg_idx), 32'h0);
  endtask

  initial begin : main
    int t;
    int r;

    @(negedge sys_clk);
    checkResetValues("reset");

    $display("[TB] table walk");
    applyStimulus(0, 16'h0000, 0);
    waitDone(400, t);
    checkOutput("pwdn_fall_cyc", pwdn_fall, 32'd10);
    checkOutput("rstn_rise_cyc", rstn_rise, 32'd15);
    checkOutput("req0_cyc", riseAt(0), 32'd36);
    checkOutput("req0_addr", 32'(addrAt(0)), 32'h3008);
    checkOutput("req0_wdata", 32'(dataAt(0)), 32'h82);
    checkOutput("req1_cyc_after_delay", riseAt(1), 32'd73);
    checkOutput("req1_addr", 32'(addrAt(1)), 32'h3103);
    checkOutput("req2_cyc", riseAt(2), 32'd86);
    checkOutput("req2_addr", 32'(addrAt(2)), 32'h3017);
    checkOutput("walk_req_count", rise_q.size(), 32'd3);
    checkOutput("walk_done_cyc", t, 32'd96);
    checkOutput("walk_done_err", 32'({cfg_done, cfg_err}), 32'b10);
    checkOutput("walk_idx", 32'(cfg_idx), 32'd3);

    $display("[TB] restart in WAIT then in DONE");
    applyStimulus(0, 16'h0000, 0);
    waitCycle(40);
    checkOutput("wait_req_low", 32'(sccb_req), 32'd0);
    cfg_restart = 1'b1;
    @(negedge sys_clk);
    cfg_restart = 1'b0;
    waitDone(400, t);
    checkOutput("restart_wait_ignored_cyc", t, 32'd96);
    checkOutput("restart_wait_req_count", rise_q.size(), 32'd3);
    r = cyc + 1;
    clearLog();
    cfg_restart = 1'b1;
    @(negedge sys_clk);
    cfg_restart = 1'b0;
    checkOutput("restart_done_pins", 32'({cfg_done, cam_pwdn, cam_rst_n}), 32'b010);
    checkOutput("restart_done_idx", 32'(cfg_idx), 32'd0);
    waitDone(400, t);
    checkOutput("rerun_pwdn_fall", pwdn_fall, r + 10);
    checkOutput("rerun_req0_cyc", riseAt(0), r + 36);
    checkOutput("rerun_done_cyc", t, r + 96);
    checkOutput("rerun_req_count", rise_q.size(), 32'd3);

    $display("[TB] ack stall");
    applyStimulus(50, 16'h0000, 0);
    waitCycle(60);
    checkOutput("stall_req_hold", 32'({sccb_req, sccb_addr, sccb_wdata}), 32'h1300882);
    waitCycle(86);
    checkOutput("stall_req_hold_late", 32'({sccb_req, sccb_addr, sccb_wdata}), 32'h1300882);
    waitDone(400, t);
    checkOutput("stall_req_count", rise_q.size(), 32'd3);
    checkOutput("stall_req1_cyc", riseAt(1), 32'd123);
    checkOutput("stall_done_cyc", t, 32'd146);

`ifdef OV5640_CFG_RETRY_EN
    $display("[TB] NACK with retries");
    applyStimulus(0, 16'h3103, 4);
    waitDone(400, t);
    checkOutput("retry_err_cyc", t, 32'd118);
    checkOutput("retry_done_err", 32'({cfg_done, cfg_err}), 32'b01);
    checkOutput("retry_err_idx", 32'(cfg_idx), 32'd2);
    repeat (100) @(negedge sys_clk);
    checkOutput("retry_req_count", rise_q.size(), 32'd5);
    checkOutput("retry_last_req_cyc", riseAt(4), 32'd109);
    applyStimulus(0, 16'h3103, 1);
    waitDone(400, t);
    checkOutput("retry_recover_cyc", t, 32'd108);
    checkOutput("retry_recover_done_err", 32'({cfg_done, cfg_err}), 32'b10);
    checkOutput("retry_recover_idx", 32'(cfg_idx), 32'd3);
    checkOutput("retry_recover_req_cyc", riseAt(2), 32'd85);
    checkOutput("retry_recover_req_addr", 32'(addrAt(2)), 32'h3103);
    checkOutput("retry_recover_req_count", rise_q.size(), 32'd4);
`else
    $display("[TB] NACK without retries");
    applyStimulus(0, 16'h3103, 1);
    waitDone(400, t);
    checkOutput("nack_err_cyc", t, 32'd82);
    checkOutput("nack_done_err", 32'({cfg_done, cfg_err}), 32'b01);
    checkOutput("nack_err_idx", 32'(cfg_idx), 32'd2);
    repeat (100) @(negedge sys_clk);
    checkOutput("nack_req_count", rise_q.size(), 32'd2);
    checkOutput("nack_err_sticky", 32'({cfg_err, sccb_req}), 32'b10);
`endif

    $display("[TB] reset during request");
    applyStimulus(50, 16'h0000, 0);
    waitCycle(50);
    checkOutput("midrst_req_before", 32'({sccb_req, sccb_addr}), 32'h13008);
    #2 sys_rst = 1'b1;
    #1 checkResetValues("midrst");
    @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
